// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with registered forwarding selects and load-use stall detection.
// Selects are computed from the ID indices one cycle early so EX muxes see a flop output.
module id_ex_stage #(
  parameter int width   = 32,
  parameter int regbits = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [regbits-1:0] id_rs,
  input  logic [regbits-1:0] id_rt,
  input  logic [regbits-1:0] id_rd,
  input  logic [width-1:0]   id_rd1,
  input  logic [width-1:0]   id_rd2,
  input  logic [width-1:0]   id_imm,
  input  logic               id_regwrite,
  input  logic               id_memtoreg,
  input  logic               id_memwrite,
  input  logic               id_alusrc,
  input  logic [2:0]         id_alucontrol,
  input  logic [regbits-1:0] mem_rd,
  input  logic               mem_regwrite,
  input  logic               flush,
  input  logic               hold,
  output logic               ex_valid,
  output logic [regbits-1:0] ex_rs,
  output logic [regbits-1:0] ex_rt,
  output logic [regbits-1:0] ex_rd,
  output logic [width-1:0]   ex_rd1,
  output logic [width-1:0]   ex_rd2,
  output logic [width-1:0]   ex_imm,
  output logic               ex_regwrite,
  output logic               ex_memtoreg,
  output logic               ex_memwrite,
  output logic               ex_alusrc,
  output logic [2:0]         ex_alucontrol,
  output logic [1:0]         ex_fwd_a,
  output logic [1:0]         ex_fwd_b,
  output logic               id_stall
);

  typedef struct packed {
    logic               valid;
    logic [regbits-1:0] rs;
    logic [regbits-1:0] rt;
    logic [regbits-1:0] rd;
    logic [width-1:0]   rd1;
    logic [width-1:0]   rd2;
    logic [width-1:0]   imm;
    logic               regwrite;
    logic               memtoreg;
    logic               memwrite;
    logic               alusrc;
    logic [2:0]         alucontrol;
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;
  } stage_t;

  stage_t stage_q, stage_d;

  logic ex_wr_ok, mem_wr_ok;
  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic stall;
  logic [1:0] fwd_a_d, fwd_b_d;

  // Register $0 never matches a producer.
  assign ex_wr_ok   = stage_q.valid & stage_q.regwrite & (stage_q.rd != '0);
  assign mem_wr_ok  = mem_regwrite & (mem_rd != '0);
  assign ex_hit_rs  = ex_wr_ok & (stage_q.rd == id_rs);
  assign ex_hit_rt  = ex_wr_ok & (stage_q.rd == id_rt);
  assign mem_hit_rs = mem_wr_ok & (mem_rd == id_rs);
  assign mem_hit_rt = mem_wr_ok & (mem_rd == id_rt);

  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    // The EX occupant is younger than the MEM occupant, so it wins.
    if (ex_hit_rs)       fwd_a_d = 2'b10;
    else if (mem_hit_rs) fwd_a_d = 2'b01;
    if (ex_hit_rt)       fwd_b_d = 2'b10;
    else if (mem_hit_rt) fwd_b_d = 2'b01;
  end

  assign stall = ~flush & id_valid & stage_q.valid & stage_q.memtoreg &
                 (stage_q.rd != '0) &
                 ((stage_q.rd == id_rs) | (stage_q.rd == id_rt));

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (hold) begin
      stage_d = stage_q;
    end else if (stall) begin
      stage_d = '0;
    end else begin
      stage_d.valid      = id_valid;
      stage_d.rs         = id_rs;
      stage_d.rt         = id_rt;
      stage_d.rd         = id_rd;
      stage_d.rd1        = id_rd1;
      stage_d.rd2        = id_rd2;
      stage_d.imm        = id_imm;
      stage_d.regwrite   = id_regwrite;
      stage_d.memtoreg   = id_memtoreg;
      stage_d.memwrite   = id_memwrite;
      stage_d.alusrc     = id_alusrc;
      stage_d.alucontrol = id_alucontrol;
      stage_d.fwd_a      = fwd_a_d;
      stage_d.fwd_b      = fwd_b_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign ex_valid      = stage_q.valid;
  assign ex_rs         = stage_q.rs;
  assign ex_rt         = stage_q.rt;
  assign ex_rd         = stage_q.rd;
  assign ex_rd1        = stage_q.rd1;
  assign ex_rd2        = stage_q.rd2;
  assign ex_imm        = stage_q.imm;
  assign ex_regwrite   = stage_q.regwrite;
  assign ex_memtoreg   = stage_q.memtoreg;
  assign ex_memwrite   = stage_q.memwrite;
  assign ex_alusrc     = stage_q.alusrc;
  assign ex_alucontrol = stage_q.alucontrol;
  assign ex_fwd_a      = stage_q.fwd_a;
  assign ex_fwd_b      = stage_q.fwd_b;
  assign id_stall      = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, load-use, hold and flush.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic        id_regwrite, id_memtoreg, id_memwrite, id_alusrc;
  logic [2:0]  id_alucontrol;
  logic [4:0]  mem_rd;
  logic        mem_regwrite;
  logic        flush, hold;
  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic        ex_regwrite, ex_memtoreg, ex_memwrite, ex_alusrc;
  logic [2:0]  ex_alucontrol;
  logic [1:0]  ex_fwd_a, ex_fwd_b;
  logic        id_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.width(32), .regbits(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .id_memwrite(id_memwrite), .id_alusrc(id_alusrc),
    .id_alucontrol(id_alucontrol),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
    .ex_alucontrol(ex_alucontrol),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .id_stall(id_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic rw, input logic mtr);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rd;
    id_regwrite = rw;
    id_memtoreg = mtr;
  endtask

  initial begin
    reset = 1'b1;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_memwrite = 1'b0; id_alusrc = 1'b0; id_alucontrol = 3'd0;
    mem_rd = '0; mem_regwrite = 1'b0; flush = 1'b0; hold = 1'b0;
    repeat (2) tick();
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_fwd_a", ex_fwd_a, 2'b00);
    chk("rst_stall", id_stall, 1'b0);

    // First instruction after reset
    #2 reset = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    id_rd1 = 32'hAAAA_0001; id_rd2 = 32'hBBBB_0002; id_imm = 32'hFFFF_FFF0;
    id_alucontrol = 3'b010; id_alusrc = 1'b1;
    tick();
    chk("load_valid", ex_valid, 1'b1);
    chk("load_rd", ex_rd, 5'd3);
    chk("load_rd1", ex_rd1, 32'hAAAA_0001);
    chk("load_imm", ex_imm, 32'hFFFF_FFF0);
    chk("load_aluc", ex_alucontrol, 3'b010);

    // Asynchronous reset mid-cycle with id_valid high
    #3 reset = 1'b1;
    #1;
    chk("async_valid", ex_valid, 1'b0);
    chk("async_rd1", ex_rd1, 32'h0);
    chk("async_rw", ex_regwrite, 1'b0);
    chk("async_aluc", ex_alucontrol, 3'b000);
    chk("async_stall", id_stall, 1'b0);
    #2 reset = 1'b0;
    tick();
    chk("post_rst_valid", ex_valid, 1'b1);
    chk("post_rst_rd1", ex_rd1, 32'hAAAA_0001);
    chk("post_rst_fwd_a", ex_fwd_a, 2'b00);
    chk("post_rst_fwd_b", ex_fwd_b, 2'b00);

    // EX-to-EX forward: add $3 in EX, ID reads $3 twice
    set_id(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0);
    tick();
    chk("exfwd_a", ex_fwd_a, 2'b10);
    chk("exfwd_b", ex_fwd_b, 2'b10);

    // EX=$4 and MEM=$4 both match rs: EX wins
    set_id(1'b1, 5'd4, 5'd7, 5'd9, 1'b1, 1'b0);
    mem_rd = 5'd4; mem_regwrite = 1'b1;
    tick();
    chk("prio_a", ex_fwd_a, 2'b10);
    chk("prio_b", ex_fwd_b, 2'b00);

    // MEM-only match on rs, EX ($9) match on rt
    set_id(1'b1, 5'd4, 5'd9, 5'd0, 1'b1, 1'b0);
    tick();
    chk("memfwd_a", ex_fwd_a, 2'b01);
    chk("memfwd_b", ex_fwd_b, 2'b10);

    // Zero register: ex_rd=0 and mem_rd=0 with writes enabled
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    mem_rd = 5'd0;
    tick();
    chk("zero_a", ex_fwd_a, 2'b00);
    chk("zero_b", ex_fwd_b, 2'b00);

    // Load-use: lw $5 enters EX
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
    mem_regwrite = 1'b0;
    tick();
    set_id(1'b1, 5'd1, 5'd5, 5'd8, 1'b1, 1'b0);
    id_rd2 = 32'h0000_D00D;
    #1;
    chk("lu_stall", id_stall, 1'b1);
    tick();
    chk("lu_bub_valid", ex_valid, 1'b0);
    chk("lu_bub_rw", ex_regwrite, 1'b0);
    chk("lu_bub_mtr", ex_memtoreg, 1'b0);
    chk("lu_bub_fwd_b", ex_fwd_b, 2'b00);
    mem_rd = 5'd5; mem_regwrite = 1'b1;
    #1;
    chk("lu_unstall", id_stall, 1'b0);
    tick();
    chk("lu_dep_valid", ex_valid, 1'b1);
    chk("lu_dep_rd", ex_rd, 5'd8);
    chk("lu_dep_fwd_a", ex_fwd_a, 2'b00);
    chk("lu_dep_fwd_b", ex_fwd_b, 2'b01);
    chk("lu_dep_rd2", ex_rd2, 32'h0000_D00D);

    // Hold for 3 cycles while ID changes
    mem_regwrite = 1'b0;
    hold = 1'b1;
    set_id(1'b1, 5'd8, 5'd2, 5'd10, 1'b1, 1'b0);
    id_rd1 = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_rd", ex_rd, 5'd8);
      chk("hold_fwd_b", ex_fwd_b, 2'b01);
      chk("hold_rd1", ex_rd1, 32'hAAAA_0001);
      id_rd2 = 32'h0000_0100 + 32'(i);
    end
    hold = 1'b0;
    tick();
    chk("unhold_rd", ex_rd, 5'd10);
    chk("unhold_rd1", ex_rd1, 32'h1234_5678);
    chk("unhold_fwd_a", ex_fwd_a, 2'b10);
    chk("unhold_fwd_b", ex_fwd_b, 2'b00);

    // Flush with load-use hazard and hold
    set_id(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1);
    id_memwrite = 1'b1;
    tick();
    set_id(1'b1, 5'd11, 5'd0, 5'd12, 1'b1, 1'b0);
    #1;
    chk("fl_pre_stall", id_stall, 1'b1);
    flush = 1'b1; hold = 1'b1;
    #1;
    chk("fl_stall", id_stall, 1'b0);
    tick();
    chk("fl_valid", ex_valid, 1'b0);
    chk("fl_rw", ex_regwrite, 1'b0);
    chk("fl_mtr", ex_memtoreg, 1'b0);
    chk("fl_mw", ex_memwrite, 1'b0);
    chk("fl_alusrc", ex_alusrc, 1'b0);
    chk("fl_aluc", ex_alucontrol, 3'b000);
    chk("fl_fwd_a", ex_fwd_a, 2'b00);
    chk("fl_rd", ex_rd, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage pipeline core. Captures decoded operands and control from ID and presents them to EX. Computes the forwarding selects one cycle early and registers them, so they directly drive the `sel` inputs of the two EX-stage operand 4:1 muxes. Detects load-use hazards, stalls ID, and inserts bubbles.

## Interface

- `width`, default 32: datapath width.
- `regbits`, default 5: register-index width.

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt`, `id_rd` in `regbits`: source and destination indices.
- `id_rd1`, `id_rd2`, `id_imm` in `width`: register-file read data and the sign-extended immediate.
- `id_regwrite`, `id_memtoreg`, `id_memwrite`, `id_alusrc` in 1: decoded control.
- `id_alucontrol` in 3: ALU operation.
- `mem_rd` in `regbits`, `mem_regwrite` in 1: destination and write enable of the instruction currently in MEM.
- `flush` in 1: branch/jump redirect; kill the instruction entering EX.
- `hold` in 1: global pipeline freeze (memory wait).
- `ex_valid` out 1, plus `ex_rs`, `ex_rt`, `ex_rd`, `ex_rd1`, `ex_rd2`, `ex_imm`, `ex_regwrite`, `ex_memtoreg`, `ex_memwrite`, `ex_alusrc`, `ex_alucontrol`: registered copies of the ID fields.
- `ex_fwd_a`, `ex_fwd_b` out 2: operand mux selects. 00 = register-file data (`ex_rd1`/`ex_rd2`), 01 = WB result, 10 = MEM ALU result, 11 = never produced.
- `id_stall` out 1: freeze PC and IF/ID this cycle.

## Operation

- Register file is write-through, so an instruction in WB never needs forwarding from ID's point of view. Only two producers matter at capture time:
  - the current EX occupant, which will be in MEM next cycle;
  - the current MEM occupant, which will be in WB next cycle.
- Match rules:
  - `exhit(r)` = `ex_valid & ex_regwrite & ex_rd != 0 & ex_rd == r`.
  - `memhit(r)` = `mem_regwrite & mem_rd != 0 & mem_rd == r`.
- Next select for operand A: 10 if `exhit(id_rs)`, else 01 if `memhit(id_rs)`, else 00. The EX occupant wins because it is younger. Operand B uses the same rule with `id_rt`.
- `id_stall` is combinational: `id_valid & ex_valid & ex_memtoreg & ex_rd != 0 & (ex_rd == id_rs | ex_rd == id_rt)`. It is forced to 0 while `flush` is 1.
- Update priority at each rising edge, highest first:
  1. `reset`: all outputs cleared.
  2. `flush`: load a bubble.
  3. `hold`: keep every register unchanged, including the selects.
  4. `id_stall`: load a bubble.
  5. Otherwise: load the ID fields and the next selects. `ex_valid` takes `id_valid`.
- Bubble: `ex_valid`, all control bits, `ex_alucontrol`, and the selects are 0. Data fields (`ex_rd1`, `ex_rd2`, `ex_imm`, indices) are don't-care, but the implementation zeroes them.
- Register index 0 never matches, so no forwarding and no stall occur on `$0`.

## Timing

- Latency is 1 cycle, ID to EX. The selects are valid at the start of the EX cycle with no combinational path from `mem_*` to `ex_fwd_*`.
- Reset is asynchronous: on assertion every output goes to 0 immediately, with no clock edge needed. `id_stall` reads 0 because `ex_valid` = 0.
- Load-use sequence:
  - Cycle N: the load is in EX, the dependent instruction is in ID, and `id_stall` = 1.
  - Edge N+1: a bubble is loaded. The load moves to MEM, so `mem_rd` now equals the load's destination.
  - Cycle N+1: `id_stall` = 0. The dependent instruction is captured with select 01 and takes the WB load data in EX.
- Reset mid-stall clears state. ID re-presents the instruction afterwards.
- `flush` together with `hold`: flush wins and the bubble is loaded.
- `flush` together with a stall condition: a bubble is loaded and `id_stall` = 0.
- `hold` together with `id_stall`: the register is unchanged. `id_stall` stays asserted while the hazard persists.

## Test plan

- Reset: assert `reset` mid-cycle with `id_valid` = 1 → all outputs 0 immediately. After release, the first edge loads ID fields with `ex_fwd_a` = `ex_fwd_b` = 00.
- EX-to-EX forward: `add $3` is in EX (`ex_rd` = 3, `ex_regwrite` = 1) and ID has `id_rs` = 3, `id_rt` = 3 → next cycle `ex_fwd_a` = `ex_fwd_b` = 10.
- Priority and zero register:
  - `mem_rd` = 4 with `mem_regwrite` = 1, EX `ex_rd` = 4 with `ex_regwrite` = 1, and `id_rs` = 4 → `ex_fwd_a` = 10.
  - `ex_rd` = 0 with `mem_rd` = 0 and `id_rs` = 0 → 00.
- Load-use: `lw $5` is in EX and ID has `id_rt` = 5 →
  - `id_stall` = 1 for 1 cycle;
  - the next EX shows `ex_valid` = 0;
  - the following EX shows the dependent instruction with `ex_fwd_b` = 01.
- Hold: hold for 3 cycles while ID inputs change → EX outputs and selects stay constant. On release, the current ID fields are captured.
- Flush: assert `flush` together with a load-use hazard and `hold` → `id_stall` = 0, and the next EX shows `ex_valid` = 0 with all controls 0.
